// File: rtl/busca_instrucao.sv
// busca_instrucao: fetches 8-bit words from instruction memory at pc and issues {opcode, immediate} downstream with a valid/ready handshake
//   in : clk, reset (sync, active-high), executar (run enable), mem_rdata/mem_ack (memory read response), instr_ready (downstream accept)
//   out: mem_addr/mem_rd (memory read request), instrucao/imediato/instr_valid (issued instruction), pc, instr_count (accepted, saturating)
module busca_instrucao (
   input  logic       clk,
   input  logic       reset,
   input  logic       executar,
   output logic [3:0] mem_addr,
   output logic       mem_rd,
   input  logic [7:0] mem_rdata,
   input  logic       mem_ack,
   output logic [3:0] instrucao,
   output logic [3:0] imediato,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [3:0] pc,
   output logic [7:0] instr_count
);
   typedef enum logic [1:0] {OCIOSO, BUSCA, EMITE} state_t;
   state_t     r_state, w_next;
   logic [3:0] r_pc;
   logic [7:0] r_ir, r_count;
   logic       w_acc;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= OCIOSO;
         r_pc    <= '0;
         r_ir    <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == BUSCA && mem_ack) r_ir <= mem_rdata;
         if (w_acc) begin
            r_pc    <= (r_ir[7:4] == 4'b0111) ? r_ir[3:0] : r_pc + 4'd1;
            r_count <= (r_count == 8'hFF) ? r_count : r_count + 8'd1;
         end
      end
   end
   // the IR only changes when leaving BUSCA, so it doubles as the held issue register
   always_comb begin
      w_acc       = r_state == EMITE && instr_ready;
      w_next      = r_state == OCIOSO ? (executar ? BUSCA : OCIOSO) :
                    r_state == BUSCA  ? (mem_ack ? EMITE : BUSCA) :
                    w_acc             ? (executar ? BUSCA : OCIOSO) : EMITE;
      mem_rd      = r_state == BUSCA;
      instr_valid = r_state == EMITE;
      mem_addr    = r_pc;
      pc          = r_pc;
      instrucao   = r_ir[7:4];
      imediato    = r_ir[3:0];
      instr_count = r_count;
   end
endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao: scoreboard bench for busca_instrucao with a variable-latency memory model
module tb_busca_instrucao;
   logic       clk = 1'b0;
   logic       reset, executar, mem_rd, mem_ack, instr_valid, instr_ready;
   logic [3:0] mem_addr, instrucao, imediato, pc;
   logic [7:0] mem_rdata, instr_count;
   logic [7:0] mem [16];
   logic [7:0] sb [$];
   logic [3:0] m_pc;
   logic [7:0] m_cnt;
   logic       ack_ovr = 1'b0;
   int         ack_delay = 0, wcnt = 0, total = 0, bad = 0;

   busca_instrucao dut (
      .clk(clk), .reset(reset), .executar(executar), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .instrucao(instrucao), .imediato(imediato),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) wcnt <= (mem_rd && !mem_ack) ? wcnt + 1 : 0;
   assign mem_ack   = ack_ovr | (mem_rd && wcnt >= ack_delay);
   assign mem_rdata = mem[mem_addr];

   task automatic wait_valid(output int n);
      n = 0;
      while (!instr_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (pc !== 4'd0 || instr_count !== 8'd0 || mem_rd !== 1'b0 || instr_valid !== 1'b0 || instrucao !== 4'd0 || imediato !== 4'd0) begin
         bad++;
         $display("FAIL reset_state got pc=%h cnt=%h rd=%b v=%b ins=%h imm=%h required all zero", pc, instr_count, mem_rd, instr_valid, instrucao, imediato);
      end
      reset = 1'b0;
      ack_ovr = 1'b1;
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || pc !== 4'd0) begin
         bad++;
         $display("FAIL idle_ack_ignored got rd=%b v=%b pc=%h required 0 0 0", mem_rd, instr_valid, pc);
      end
      ack_ovr = 1'b0;
      m_pc = 4'd0;
      m_cnt = 8'd0;
   endtask

   task automatic test_stream;
      int n;
      logic [7:0] exp;
      mem[0] = 8'h25; mem[1] = 8'h03; mem[2] = 8'h7A; mem[10] = 8'h91;
      sb.push_back(8'h25); sb.push_back(8'h03); sb.push_back(8'h7A); sb.push_back(8'h91);
      executar = 1'b1;
      instr_ready = 1'b1;
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b1 || mem_addr !== 4'd0) begin
         bad++;
         $display("FAIL latency_rd got rd=%b addr=%h required 1 0", mem_rd, mem_addr);
      end
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1) begin
         bad++;
         $display("FAIL latency_valid got %b required 1", instr_valid);
      end
      for (int i = 0; i < 4; i++) begin
         wait_valid(n);
         total++;
         if (n != (i == 0 ? 0 : 1)) begin
            bad++;
            $display("FAIL throughput%0d got wait=%0d required %0d", i, n, i == 0 ? 0 : 1);
         end
         exp = sb.pop_front();
         total++;
         if (instr_valid !== 1'b1 || {instrucao, imediato} !== exp) begin
            bad++;
            $display("FAIL issue%0d got v=%b %h%h required %h", i, instr_valid, instrucao, imediato, exp);
         end
         @(negedge clk);
         m_pc = (exp[7:4] == 4'h7) ? exp[3:0] : m_pc + 4'd1;
         m_cnt = m_cnt + 8'd1;
         total++;
         if (pc !== m_pc || mem_addr !== m_pc || instr_count !== m_cnt) begin
            bad++;
            $display("FAIL pc_after%0d got pc=%h addr=%h cnt=%0d required pc=%h cnt=%0d", i, pc, mem_addr, instr_count, m_pc, m_cnt);
         end
         if (i == 2) executar = 1'b0;
      end
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || {instrucao, imediato} !== 8'h91) begin
         bad++;
         $display("FAIL idle_hold got rd=%b v=%b %h%h required 0 0 91", mem_rd, instr_valid, instrucao, imediato);
      end
   endtask

   task automatic test_stall;
      int n;
      logic [7:0] exp;
      mem[11] = 8'hC4;
      sb.push_back(8'hC4);
      instr_ready = 1'b0;
      executar = 1'b1;
      wait_valid(n);
      total++;
      if (n >= 20) begin
         bad++;
         $display("FAIL stall_timeout got no instr_valid required 1");
      end
      executar = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total++;
         if (instr_valid !== 1'b1 || {instrucao, imediato} !== sb[0] || pc !== m_pc || instr_count !== m_cnt) begin
            bad++;
            $display("FAIL stall%0d got v=%b %h%h pc=%h cnt=%0d required 1 %h pc=%h cnt=%0d", i, instr_valid, instrucao, imediato, pc, instr_count, sb[0], m_pc, m_cnt);
         end
         @(negedge clk);
      end
      instr_ready = 1'b1;
      exp = sb.pop_front();
      @(negedge clk);
      m_pc = (exp[7:4] == 4'h7) ? exp[3:0] : m_pc + 4'd1;
      m_cnt = m_cnt + 8'd1;
      total++;
      if (pc !== m_pc || instr_count !== m_cnt || instr_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_release got pc=%h cnt=%0d v=%b required pc=%h cnt=%0d v=0", pc, instr_count, instr_valid, m_pc, m_cnt);
      end
   endtask

   task automatic test_ack_delay;
      logic [7:0] exp;
      mem[12] = 8'h5E;
      sb.push_back(8'h5E);
      ack_delay = 3;
      executar = 1'b1;
      @(negedge clk);
      executar = 1'b0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (mem_rd !== 1'b1 || mem_addr !== m_pc || instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL wait_state%0d got rd=%b addr=%h v=%b required 1 %h 0", i, mem_rd, mem_addr, instr_valid, m_pc);
         end
         @(negedge clk);
      end
      exp = sb.pop_front();
      total++;
      if (instr_valid !== 1'b1 || mem_rd !== 1'b0 || {instrucao, imediato} !== exp) begin
         bad++;
         $display("FAIL delayed_issue got v=%b rd=%b %h%h required 1 0 %h", instr_valid, mem_rd, instrucao, imediato, exp);
      end
      @(negedge clk);
      m_pc = m_pc + 4'd1;
      m_cnt = m_cnt + 8'd1;
      total++;
      if (pc !== m_pc || instr_count !== m_cnt) begin
         bad++;
         $display("FAIL delayed_accept got pc=%h cnt=%0d required pc=%h cnt=%0d", pc, instr_count, m_pc, m_cnt);
      end
      ack_delay = 0;
   endtask

   task automatic test_wrap_saturate;
      int n;
      logic [7:0] exp;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_pc = 4'd0;
      m_cnt = 8'd0;
      sb.delete();
      for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
      executar = 1'b1;
      instr_ready = 1'b1;
      for (int k = 0; k < 260; k++) begin
         sb.push_back(mem[m_pc]);
         wait_valid(n);
         exp = sb.pop_front();
         total++;
         if (n >= 20 || {instrucao, imediato} !== exp) begin
            bad++;
            $display("FAIL run_issue%0d got v=%b %h%h required 1 %h", k, instr_valid, instrucao, imediato, exp);
         end
         @(negedge clk);
         m_pc = m_pc + 4'd1;
         m_cnt = (m_cnt == 8'd255) ? m_cnt : m_cnt + 8'd1;
         total++;
         if (pc !== m_pc || instr_count !== m_cnt) begin
            bad++;
            $display("FAIL run_state%0d got pc=%h cnt=%0d required pc=%h cnt=%0d", k, pc, instr_count, m_pc, m_cnt);
         end
      end
      total++;
      if (instr_count !== 8'd255) begin
         bad++;
         $display("FAIL saturate got %0d required 255", instr_count);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      wait_valid(n);
      total++;
      if (n >= 20 || instr_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_issue_reach got wait=%0d required valid", n);
      end
      reset = 1'b1;
      @(negedge clk);
      sb.delete();
      m_pc = 4'd0;
      m_cnt = 8'd0;
      total++;
      if (instr_valid !== 1'b0 || pc !== 4'd0 || instr_count !== 8'd0 || instrucao !== 4'd0 || imediato !== 4'd0) begin
         bad++;
         $display("FAIL reset_in_issue got v=%b pc=%h cnt=%0d %h%h required 0 0 0 00", instr_valid, pc, instr_count, instrucao, imediato);
      end
      reset = 1'b0;
      ack_delay = 5;
      executar = 1'b1;
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b1) begin
         bad++;
         $display("FAIL fetch_start got rd=%b required 1", mem_rd);
      end
      reset = 1'b1;
      executar = 1'b0;
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_fetch got rd=%b required 0", mem_rd);
      end
      reset = 1'b0;
      ack_delay = 0;
      ack_ovr = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (instr_valid !== 1'b0 || mem_rd !== 1'b0 || instr_count !== 8'd0) begin
            bad++;
            $display("FAIL late_ack%0d got v=%b rd=%b cnt=%0d required 0 0 0", i, instr_valid, mem_rd, instr_count);
         end
      end
      ack_ovr = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      executar = 1'b0;
      instr_ready = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      test_reset();
      test_stream();
      test_stall();
      test_ack_delay();
      test_wrap_saturate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 The module SHALL have the following ports, one per line (name, direction, width, meaning), clock and reset first:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- executar  input  1  run enable: 1 = fetch and issue instructions, 0 = stop after current issue.
- mem_addr  output  4  instruction memory address (= PC while fetching).
- mem_rd  output  1  instruction memory read request.
- mem_rdata  input  8  instruction word: [7:4] opcode, [3:0] immediate.
- mem_ack  input  1  memory read data valid; sampled only while mem_rd=1.
- instrucao  output  4  opcode issued to the control decoder.
- imediato  output  4  immediate field issued with the opcode.
- instr_valid  output  1  instrucao/imediato valid.
- instr_ready  input  1  downstream (control/datapath) accepts the issued instruction.
- pc  output  4  current program counter.
- instr_count  output  8  count of accepted instructions.
REQ-002 Reset SHALL be synchronous and active-high on `reset`, with one clock `clk`.

Function
REQ-003 The block SHALL implement an FSM with states OCIOSO, BUSCA and EMITE.
REQ-004 OCIOSO: mem_rd=0 and instr_valid=0; if executar=1, the next state SHALL be BUSCA.
REQ-005 BUSCA: mem_rd=1 and mem_addr=pc; mem_rd SHALL be held until mem_ack=1.
REQ-006 BUSCA: on mem_ack=1, mem_rdata SHALL be latched into an instruction register and the next state SHALL be EMITE.
REQ-007 mem_ack SHALL be ignored in OCIOSO and EMITE.
REQ-008 EMITE: instr_valid=1 and mem_rd=0.
REQ-009 EMITE: instrucao=IR[7:4] and imediato=IR[3:0], both held stable until the handshake.
REQ-010 Handshake: an instruction SHALL be accepted on the first rising edge with instr_valid=1 and instr_ready=1; instr_valid SHALL deassert the following cycle.
REQ-011 On acceptance, if instrucao=4'b0111 (JMP), pc SHALL load imediato.
REQ-012 On acceptance of any other opcode, pc SHALL increment by 1 modulo 16 (15 -> 0 wraps silently).
REQ-013 On acceptance, instr_count SHALL increment by 1, saturating at 255.
REQ-014 After acceptance, the next state SHALL be BUSCA if executar=1, else OCIOSO.
REQ-015 executar=0 during BUSCA or EMITE SHALL NOT abort the in-flight fetch or issue.
REQ-016 Latency: executar=1 in OCIOSO at edge N gives mem_rd=1 in cycle N+1; zero-wait mem_ack in that cycle gives instr_valid=1 in cycle N+2.
REQ-017 Back-to-back throughput with zero-wait memory and instr_ready tied 1 SHALL be one instruction per 2 cycles.
REQ-018 Opcodes other than JMP, including 4'b1000-4'b1111, SHALL be issued unmodified; decoding is done downstream.
REQ-019 In OCIOSO, instrucao and imediato SHALL hold the last issued values; in BUSCA they SHALL hold their prior values.
REQ-020 mem_addr SHALL equal pc in all states.

Reset
REQ-021 When reset=1 at a rising edge: state=OCIOSO, pc=0, instr_count=0, IR=8'h00, mem_rd=0, instr_valid=0, instrucao=0, imediato=0.
REQ-022 Reset SHALL take priority over all other inputs, including mid-fetch (mem_rd drops the next cycle, later mem_ack ignored) and mid-issue (pending instruction discarded, not counted).

Verification
REQ-023 Reset, then executar=1, memory words {0:8'h25, 1:8'h03}, zero-wait ack, instr_ready=1 -> issues (0010,0101) then (0000,0011); pc 0->1->2; instr_count=2.
REQ-024 Word at addr 2 = 8'h7A (JMP 10), accepted -> pc=10 and the next mem_addr=10.
REQ-025 instr_ready=0 for 5 cycles during EMITE -> instr_valid, instrucao and imediato stable for all 5 cycles; pc and instr_count unchanged until ready=1.
REQ-026 mem_ack delayed 3 cycles -> mem_rd held high for 4 cycles at a constant mem_addr; instr_valid=0 throughout.
REQ-027 pc=15 with a non-JMP accepted -> pc=0; 256 accepted instructions -> instr_count=255.
REQ-028 reset=1 while in EMITE with instr_ready=1 -> no count increment, pc=0, instr_valid=0 the next cycle.
